cordic_kscale_accum: RTL and testbench
======================================

// Module: cordic_kscale_accum
// PURPOSE
//  Multi-channel CORDIC gain accumulator for the floating-point CORDIC datapath.
//  - Per request it looks up K_i = 1/sqrt(1+2^-2i) for iteration index i.
//  - It multiplies K_i into a per-channel running product and returns the updated product.
//  - The product is the total rotation gain K used to post-scale the CORDIC result mantissa.
//  - Pipelined, valid/ready on both sides, one request per cycle.
// PARAMETERS
//  W        24  mantissa width; K values are UQ0.W (0x800000 = 0.5 at W=24)
//  IDX_W     4  iteration index width
//  MAX_IDX  15  highest index held in ROM; idx > MAX_IDX uses K = 2^W-1 (~1.0)
//  NCH       2  independent accumulator channels
//  CH_W      1  channel id width, clog2(NCH), minimum 1
//  CNT_W     5  per-channel factor counter width
// PORTS
//  iClk       in   1      clock, all logic on rising edge
//  iRst       in   1      synchronous reset, active-high
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid & in_ready
//  in_clr     in   1      start a new sequence: load K_i instead of multiplying
//  in_ch      in   CH_W   target channel; values >= NCH are ignored (no write, no output)
//  in_idx     in   IDX_W  iteration index i
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      downstream accepts the result
//  out_ch     out  CH_W   channel of the result
//  out_k      out  W      updated running product, UQ0.W
//  out_cnt    out  CNT_W  factors accumulated in this channel, including this one
// BEHAVIOUR
//  - Reset: out_valid=0, out_k=0, out_ch=0, out_cnt=0, s1_valid=0, all acc[ch]=0, all cnt[ch]=0.
//    A reset mid-operation discards in-flight requests. in_ready=1 in the first cycle after reset.
//  - adv = !out_valid | out_ready; in_ready = adv (combinational).
//  - S1 (cycle t): an accepted request registers ch/clr/valid; the ROM registers K_i.
//  - S2 (cycle t+1, when adv): compute p = rom_q*acc[ch] (2W bits).
//    - new = (in_clr | !acc[ch][W-1]) ? rom_q : p[2W-1:W]
//    - Write acc[ch]<=new and out_k<=new.
//    - cnt[ch] <= clr ? 1 : sat_inc(cnt[ch]); cnt saturates at 2^CNT_W-1.
//    - out_valid=1 at t+2.
//  - Latency: 2 cycles from acceptance to out_valid. Throughput: 1/cycle.
//  - Back-to-back requests on the same channel need no stall; S2 reads acc at its own cycle.
//  - Stall (out_valid & !out_ready): S1, ROM output, acc, cnt and out_* all hold.
//    No request is lost or duplicated.
//  - MSB rule: every K_i >= 0.5 and every product >= 0.607, so acc MSB=1 means "sequence active".
//    acc MSB=0 (reset state) forces a load. No normalisation shift is ever applied.
//  - Index saturation: idx > MAX_IDX uses K = 2^W-1; the product then shrinks by at most 1 LSB (truncate).
//  - S1 clr on channel a and S2 on channel b != a in the same cycle: independent, no interaction.
// CONFIGURATION
//  CORDIC_KSCALE_ROUND_EN
//    - Defined: new = (p + 2^(W-1)) >> W, round half-up. The sum cannot exceed 2^2W-1, so no saturation.
//    - Undefined: new = p[2W-1:W], truncation. This matches the legacy single-channel gain path bit-exactly.
// STRUCTURE
//  - Package cordic_kscale_pkg:
//    - Function kscale_rom_val(i,W) = floor(2^W/sqrt(1+2^-2i)).
//    - Constant KSCALE_ONE = 2^W-1.
//    - Type for {ch,clr,valid} in the S1 register.
//  - Sub-module cordic_kscale_rom:
//    - Registered ROM, depth MAX_IDX+1, read enable = adv.
//    - Contents from kscale_rom_val; out-of-range index handled here.
//  - Top holds: S1 regs, acc/cnt arrays (NCH x W, NCH x CNT_W), multiplier, output regs, adv logic.
// TESTING (W=24, NCH=2, truncate unless noted)
//  1 Reset, then ch0 idx0 clr=0 -> out_k=0xB504F3, out_cnt=1, out_valid at t+2.
//  2 Ch0 idx 0..15 back-to-back, out_ready=1 -> 16 results, one per cycle.
//    Final out_k within 16 LSB of 10188014 (0.607253), out_cnt=16.
//  3 Interleave ch0/ch1 (ch1 idx starting at 3) -> each channel equals its own golden product; no crosstalk.
//  4 Hold out_ready=0 for 5 cycles during a burst -> in_ready=0.
//    out_k/out_ch stable; no result lost or duplicated after release.
//  5 Ch0 mid-sequence, then clr idx1 -> out_k=kscale_rom_val(1), out_cnt=1.
//    Idx 20 next -> out_k drops by <=1 LSB.
//  6 Assert iRst with 2 requests in flight -> next cycle out_valid=0, acc=0.
//    Following idx0 yields 0xB504F3.
//  7 CORDIC_KSCALE_ROUND_EN defined, rerun 2 -> final within 8 LSB of 10188014.

Source files
------------

// File: rtl/cordic_kscale_pkg.sv
// Shared types and constants for the CORDIC gain accumulator.
// Holds the K_i ROM generator used at elaboration time.
package cordic_kscale_pkg;

    localparam int KSCALE_W = 24;
    localparam logic [KSCALE_W-1:0] KSCALE_ONE = '1;
    localparam int KSCALE_CH_W = 1;

    typedef struct packed {
        logic [KSCALE_CH_W-1:0] ch;
        logic                   clr;
        logic                   valid;
    } s1_t;

    function automatic logic [63:0] kscale_isqrt(input logic [127:0] n);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 63; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (({64'd0, t} * {64'd0, t}) <= n) begin
                r = t;
            end
        end
        return r;
    endfunction

    // floor(2^w / sqrt(1 + 2^-2i)) == floor(sqrt(2^(2w+2i) / (4^i + 1)))
    function automatic logic [63:0] kscale_rom_val(input int i, input int w);
        logic [127:0] num;
        logic [127:0] den;
        num = 128'd1 << (2 * w + 2 * i);
        den = (128'd1 << (2 * i)) + 128'd1;
        return kscale_isqrt(num / den);
    endfunction

endpackage

// File: rtl/cordic_kscale_accum_rom.sv
// Registered K_i lookup; indices above MAX_IDX read as ~1.0.
// Contents are fixed at elaboration from kscale_rom_val.
module cordic_kscale_rom
    import cordic_kscale_pkg::*;
#(
    parameter int W       = 24,
    parameter int IDX_W   = 4,
    parameter int MAX_IDX = 15
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [W-1:0]     q
);

    localparam logic [W-1:0] K_ONE = '1;

    logic [W-1:0] tab [MAX_IDX+1];
    logic [W-1:0] k_sel;

    for (genvar g = 0; g <= MAX_IDX; g++) begin : g_tab
        localparam logic [63:0] V = kscale_rom_val(g, W);
        assign tab[g] = V[W-1:0];
    end

    // Select the table entry, defaulting to ~1.0 when idx is past the table.
    always_comb begin
        k_sel = K_ONE;
        for (int i = 0; i <= MAX_IDX; i++) begin
            if (idx == IDX_W'(i)) begin
                k_sel = tab[i];
            end
        end
    end

    // Read register, advancing only with the pipeline.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            q <= '0;
        end else if (en) begin
            q <= k_sel;
        end
    end

endmodule

// File: rtl/cordic_kscale_accum.sv
// Multi-channel CORDIC gain accumulator, 2-stage valid/ready pipeline.
// CORDIC_KSCALE_ROUND_EN selects round-half-up instead of truncation.
module cordic_kscale_accum
    import cordic_kscale_pkg::*;
#(
    parameter int W       = 24,
    parameter int IDX_W   = 4,
    parameter int MAX_IDX = 15,
    parameter int NCH     = 2,
    parameter int CH_W    = KSCALE_CH_W,
    parameter int CNT_W   = 5
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_clr,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [W-1:0]     out_k,
    output logic [CNT_W-1:0] out_cnt
);

`ifdef CORDIC_KSCALE_ROUND_EN
    localparam logic [2*W-1:0] RND = (2*W)'(1) << (W - 1);
`else
    localparam logic [2*W-1:0] RND = '0;
`endif

    s1_t             s1;
    logic            adv;
    logic            ch_ok;
    logic            s2_fire;
    logic [W-1:0]    rom_q;
    logic [W-1:0]    acc [NCH];
    logic [CNT_W-1:0] cnt [NCH];
    logic [W-1:0]    acc_rd;
    logic [CNT_W-1:0] cnt_rd;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    mul_k;
    logic [W-1:0]    new_k;
    logic [CNT_W-1:0] new_cnt;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;
    assign s2_fire  = adv & s1.valid;

    cordic_kscale_rom #(
        .W       (W),
        .IDX_W   (IDX_W),
        .MAX_IDX (MAX_IDX)
    ) u_rom (
        .iClk (iClk),
        .iRst (iRst),
        .en   (adv),
        .idx  (in_idx),
        .q    (rom_q)
    );

    // Requests for channels that do not exist are dropped at the door.
    always_comb begin
        ch_ok = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (in_ch == CH_W'(c)) begin
                ch_ok = 1'b1;
            end
        end
    end

    // S1 holds the request's control while the ROM fetches K_i.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1 <= '0;
        end else if (adv) begin
            s1 <= '{ch: in_ch, clr: in_clr, valid: in_valid & ch_ok};
        end
    end

    // Read the target channel's state as it stands in S2's own cycle.
    always_comb begin
        acc_rd = '0;
        cnt_rd = '0;
        for (int c = 0; c < NCH; c++) begin
            if (s1.ch == CH_W'(c)) begin
                acc_rd = acc[c];
                cnt_rd = cnt[c];
            end
        end
    end

    assign prod  = {{W{1'b0}}, rom_q} * {{W{1'b0}}, acc_rd};
    assign mul_k = W'((prod + RND) >> W);

    // A clear MSB means no live sequence, so K_i is loaded directly.
    always_comb begin
        new_k   = mul_k;
        new_cnt = cnt_rd;
        if (s1.clr || !acc_rd[W-1]) begin
            new_k = rom_q;
        end
        if (s1.clr) begin
            new_cnt = CNT_W'(1);
        end else if (!(&cnt_rd)) begin
            new_cnt = cnt_rd + CNT_W'(1);
        end
    end

    // Per-channel running product and factor count.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int c = 0; c < NCH; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (s2_fire && s1.ch == CH_W'(c)) begin
                    acc[c] <= new_k;
                    cnt[c] <= new_cnt;
                end
            end
        end
    end

    // Output register, held while downstream stalls.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_k     <= '0;
            out_cnt   <= '0;
        end else if (adv) begin
            out_valid <= s1.valid;
            if (s1.valid) begin
                out_ch  <= s1.ch;
                out_k   <= new_k;
                out_cnt <= new_cnt;
            end
        end
    end

endmodule

// File: tb/tb_cordic_kscale_accum.sv
// Directed bench for cordic_kscale_accum.
// Model recomputes K_i in real arithmetic and tracks each channel.
module tb_cordic_kscale_accum;

    localparam int W       = 24;
    localparam int IDX_W   = 5;
    localparam int MAX_IDX = 15;
    localparam int NCH     = 2;
    localparam int CH_W    = 1;
    localparam int CNT_W   = 5;

`ifdef CORDIC_KSCALE_ROUND_EN
    localparam longint RND = 64'd1 << (W - 1);
    localparam int     TOL = 8;
`else
    localparam longint RND = 0;
    localparam int     TOL = 16;
`endif

    logic             iClk = 1'b0;
    logic             iRst;
    logic             in_valid;
    logic             in_ready;
    logic             in_clr;
    logic [CH_W-1:0]  in_ch;
    logic [IDX_W-1:0] in_idx;
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [W-1:0]     out_k;
    logic [CNT_W-1:0] out_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [29:0] got_q [$];
    logic [29:0] exp_q [$];
    int          got_t [$];
    longint      mk [NCH];
    int          mc [NCH];

    cordic_kscale_accum #(
        .W(W), .IDX_W(IDX_W), .MAX_IDX(MAX_IDX),
        .NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)
    ) dut (
        .iClk(iClk), .iRst(iRst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_clr(in_clr), .in_ch(in_ch), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_k(out_k), .out_cnt(out_cnt)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        if (!iRst && out_valid && out_ready) begin
            got_q.push_back({out_ch, out_cnt, out_k});
            got_t.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic longint k_of(input int i);
        real r;
        if (i > MAX_IDX) return (longint'(1) << W) - 1;
        r = $floor((2.0 ** W) / $sqrt(1.0 + 2.0 ** (-2 * i)));
        return longint'($rtoi(r));
    endfunction

    function automatic void model(input int ch, input int idx, input bit clr);
        longint k;
        longint nk;
        logic [29:0] e;
        k = k_of(idx);
        if (clr || ((mk[ch] >> (W - 1)) & 1) == 0) nk = k;
        else nk = (mk[ch] * k + RND) >> W;
        mc[ch] = clr ? 1 : (mc[ch] == 31 ? 31 : mc[ch] + 1);
        mk[ch] = nk;
        e = {1'(ch), 5'(mc[ch]), 24'(nk)};
        exp_q.push_back(e);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input longint obs,
                             input longint tgt, input longint tol);
        longint d;
        d = obs > tgt ? obs - tgt : tgt - obs;
        n_assert++;
        assert (d <= tol) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d +/- %0d",
                   tag, obs, tgt, tol);
        end
    endtask

    task automatic send(input int ch, input int idx, input bit clr);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_ch    = CH_W'(ch);
        in_idx   = IDX_W'(idx);
        in_clr   = clr;
        @(negedge iClk);
        while (!in_ready && g < 50) begin
            @(negedge iClk);
            g++;
        end
        if (g >= 50) check("send_timeout", {63'd0, in_ready}, 64'd1);
        else model(ch, idx, clr);
        @(posedge iClk);
        #1;
        in_valid = 1'b0;
        in_clr   = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge iClk);
        #1;
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_n"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check(tag, {34'd0, got_q[i]}, {34'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
        got_t.delete();
    endtask

    initial begin
        logic [29:0] e;
        iRst      = 1'b1;
        in_valid  = 1'b0;
        in_clr    = 1'b0;
        in_ch     = '0;
        in_idx    = '0;
        out_ready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            mk[c] = 0;
            mc[c] = 0;
        end
        repeat (3) @(posedge iClk);
        #1;
        iRst = 1'b0;

        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_k", 64'(out_k), 64'd0);
        check("rst_ch", 64'(out_ch), 64'd0);
        check("rst_cnt", 64'(out_cnt), 64'd0);
        check("rst_ready", {63'd0, in_ready}, 64'd1);

        // first request after reset loads K_0 even without clr
        send(0, 0, 1'b0);
        check("t1_lat_early", {63'd0, out_valid}, 64'd0);
        @(posedge iClk);
        #1;
        check("t1_lat", {63'd0, out_valid}, 64'd1);
        check("t1_k", 64'(out_k), 64'hB504F3);
        check("t1_cnt", 64'(out_cnt), 64'd1);
        settle();
        compare_q("t1_q");

        // full 16-factor sequence, one request per cycle
        send(0, 0, 1'b1);
        for (int i = 1; i < 16; i++) send(0, i, 1'b0);
        settle();
        if (got_t.size() == 16) check("t2_tput", 64'(got_t[15] - got_t[0]), 64'd15);
        else check("t2_nres", 64'(got_t.size()), 64'd16);
        check_tol("t2_final", longint'(out_k), 10188014, TOL);
        check("t2_cnt", 64'(out_cnt), 64'd16);
        compare_q("t2_q");

        // interleaved channels
        for (int i = 0; i < 6; i++) begin
            send(0, i, i == 0);
            send(1, i + 3, i == 0);
        end
        settle();
        compare_q("t3_q");

        // downstream stall in the middle of a burst
        send(1, 3, 1'b1);
        send(1, 4, 1'b0);
        send(1, 5, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ch     = 1'b1;
        in_idx    = IDX_W'(6);
        e = exp_q.size() > 1 ? exp_q[1] : 30'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge iClk);
            check("t4_ready", {63'd0, in_ready}, 64'd0);
            check("t4_valid", {63'd0, out_valid}, 64'd1);
            check("t4_k", 64'(out_k), 64'(e[23:0]));
            check("t4_ch", 64'(out_ch), 64'd1);
        end
        @(posedge iClk);
        #1;
        out_ready = 1'b1;
        send(1, 6, 1'b0);
        settle();
        compare_q("t4_q");

        // restart mid-sequence, then an out-of-table index
        send(0, 0, 1'b1);
        send(0, 1, 1'b0);
        send(0, 2, 1'b0);
        send(0, 1, 1'b1);
        send(0, 20, 1'b0);
        settle();
        e = got_q.size() > 3 ? got_q[3] : 30'd0;
        check("t5_clr_k", 64'(e[23:0]), 64'(k_of(1)));
        check("t5_clr_cnt", 64'(e[28:24]), 64'd1);
        check("t5_sat_k", 64'(out_k), 64'(k_of(1) - 1));
        check("t5_sat_cnt", 64'(out_cnt), 64'd2);
        compare_q("t5_q");

        // reset with two requests in flight
        send(0, 3, 1'b1);
        send(1, 4, 1'b1);
        iRst = 1'b1;
        @(posedge iClk);
        #1;
        check("t6_valid", {63'd0, out_valid}, 64'd0);
        check("t6_k", 64'(out_k), 64'd0);
        check("t6_cnt", 64'(out_cnt), 64'd0);
        iRst = 1'b0;
        got_q.delete();
        exp_q.delete();
        got_t.delete();
        for (int c = 0; c < NCH; c++) begin
            mk[c] = 0;
            mc[c] = 0;
        end
        send(0, 0, 1'b0);
        @(posedge iClk);
        #1;
        check("t6_k0", 64'(out_k), 64'hB504F3);
        check("t6_cnt0", 64'(out_cnt), 64'd1);
        send(1, 0, 1'b0);
        @(posedge iClk);
        #1;
        check("t6_k1", 64'(out_k), 64'hB504F3);
        check("t6_ch1", 64'(out_ch), 64'd1);
        settle();
        compare_q("t6_q");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
